// File: rtl/fracture_det_if.sv
// Register-side bundle between the FX-bus register block (master) and the
// fracture detector (slave): threshold and clear strobes in, status out.
interface fracture_det_if #(
  parameter int CH = 8
);
  logic [15:0]   cfg_ring_th;
  logic [CH-1:0] clr_fracture;
  logic [CH-1:0] stu_fracture;
  logic          frac_pulse;
  logic          win_tick;

  modport master (
    output cfg_ring_th,
    output clr_fracture,
    input  stu_fracture,
    input  frac_pulse,
    input  win_tick
  );

  modport slave (
    input  cfg_ring_th,
    input  clr_fracture,
    output stu_fracture,
    output frac_pulse,
    output win_tick
  );
endinterface

// File: rtl/fracture_det.sv
// Per-channel ring-pulse counter and fracture detector.
// Each channel's synchronised rising edges are counted over a fixed window of
// WIN_CYC cycles; at the window's evaluation cycle any channel whose count has
// reached the latched threshold sets its sticky status bit.
module fracture_det #(
  parameter int CH      = 8,
  parameter int WIN_CYC = 50000,
  parameter int WIN_W   = 16
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic [CH-1:0] ring_in,
  fracture_det_if.slave fx
);

  typedef enum logic [1:0] {
    S_ARM   = 2'd0,
    S_COUNT = 2'd1,
    S_EVAL  = 2'd2
  } state_t;

  // Last window-counter value spent in S_COUNT; the next cycle is S_EVAL.
  localparam logic [WIN_W-1:0] LAST_CNT = WIN_W'(WIN_CYC - 2);

  state_t          state;
  logic [WIN_W-1:0] win_cnt;
  logic [15:0]     th_lat;
  logic [15:0]     cnt [CH];

  logic [CH-1:0]   sync1;
  logic [CH-1:0]   sync2;
  logic [CH-1:0]   sync3;
  logic [CH-1:0]   rise;
  logic [CH-1:0]   set_vec;

  // Two-flop synchroniser per channel plus one extra stage for edge detection.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage sample the previous
      // stage's old value, so this really is a three-deep shift register.
      sync1 <= ring_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

  // Channels that reach the latched threshold; only meaningful during S_EVAL.
  always_comb begin
    // NOTE: default first so every path assigns set_vec and no latch is inferred.
    set_vec = '0;
    if (state == S_EVAL && th_lat != 16'd0) begin
      for (int i = 0; i < CH; i++) begin
        set_vec[i] = (cnt[i] >= th_lat);
      end
    end
  end

  // Window sequencer: arm, count for WIN_CYC-1 cycles, evaluate for one cycle.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_ARM;
      win_cnt <= '0;
      th_lat  <= '0;
      // NOTE: the counter array is a bank of flops, not a RAM, so it is
      // cleared on reset along with the rest of the window state.
      for (int i = 0; i < CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      case (state)
        S_ARM, S_EVAL: begin
          // Start a fresh window; an edge arriving now belongs to it.
          th_lat  <= fx.cfg_ring_th;
          win_cnt <= '0;
          for (int i = 0; i < CH; i++) begin
            cnt[i] <= {15'd0, rise[i]};
          end
          state <= S_COUNT;
        end
        S_COUNT: begin
          win_cnt <= win_cnt + 1'b1;
          for (int i = 0; i < CH; i++) begin
            if (cnt[i] != 16'hFFFF) begin
              cnt[i] <= cnt[i] + {15'd0, rise[i]};
            end
          end
          if (win_cnt == LAST_CNT) begin
            state <= S_EVAL;
          end
        end
        default: state <= S_ARM;
      endcase
    end
  end

  // Sticky status with per-bit clear; a set in the same cycle beats the clear.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      fx.stu_fracture <= '0;
      fx.frac_pulse   <= 1'b0;
      fx.win_tick     <= 1'b0;
    end else begin
      fx.stu_fracture <= (fx.stu_fracture & ~fx.clr_fracture) | set_vec;
      fx.frac_pulse   <= |(set_vec & ~fx.stu_fracture);
      fx.win_tick     <= (state == S_EVAL);
    end
  end

endmodule

// File: tb/tb_fracture_det.sv
// Bench for fracture_det: directed scenarios plus randomised ring/clear/threshold
// traffic, every cycle compared against a window-schedule reference model.
module tb_fracture_det;

  localparam int CH = 8;
  localparam int W  = 100;

  logic          clk_sys = 1'b0;
  logic          rst_n   = 1'b0;
  logic [CH-1:0] ring_in = '0;

  fracture_det_if #(.CH(CH)) fx ();

  fracture_det #(
    .CH      (CH),
    .WIN_CYC (W),
    .WIN_W   (16)
  ) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .ring_in (ring_in),
    .fx      (fx)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  // Reference model. Cycle n is the clock period ending at the n-th rising
  // edge after reset release. Windows start on cycles 1, 1+W, 1+2W, ...;
  // the first cycle of window k+1 is the evaluation cycle of window k.
  // A ring_in value driven during cycle m shows up as an edge in cycle m+2.
  int            n;
  logic [CH-1:0] hist1, hist2, hist3;
  int            cnt_m [CH];
  int            th_m;
  logic [CH-1:0] stu_m;
  logic          pulse_m;
  logic          tick_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    n       = 0;
    hist1   = '0;
    hist2   = '0;
    hist3   = '0;
    th_m    = 0;
    stu_m   = '0;
    pulse_m = 1'b0;
    tick_m  = 1'b0;
    for (int i = 0; i < CH; i++) cnt_m[i] = 0;
  endtask

  // One clock cycle: update the model at the edge, compare at the falling edge.
  task automatic step();
    logic [CH-1:0] edge_now;
    logic [CH-1:0] set_now;
    bit            new_win;
    bit            evaluate;
    @(posedge clk_sys);
    n++;
    edge_now = hist2 & ~hist3;
    hist3    = hist2;
    hist2    = hist1;
    hist1    = ring_in;
    new_win  = ((n - 1) % W) == 0;
    evaluate = new_win && (n > 1);
    set_now  = '0;
    if (evaluate && th_m != 0) begin
      for (int i = 0; i < CH; i++) set_now[i] = (cnt_m[i] >= th_m);
    end
    for (int i = 0; i < CH; i++) begin
      cnt_m[i] = new_win ? int'(edge_now[i]) : cnt_m[i] + int'(edge_now[i]);
    end
    if (new_win) th_m = int'(fx.cfg_ring_th);
    pulse_m = |(set_now & ~stu_m);
    stu_m   = (stu_m & ~fx.clr_fracture) | set_now;
    tick_m  = evaluate;
    @(negedge clk_sys);
    check("stu", fx.stu_fracture, stu_m);
    check("pulse", fx.frac_pulse, pulse_m);
    check("tick", fx.win_tick, tick_m);
    fx.clr_fracture = '0;
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  // Advance until the coming cycle is an evaluation cycle.
  task automatic to_eval_next();
    while (n % W != 0) step();
  endtask

  task automatic wait_tick();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2 * W && !got; i++) begin
      step();
      got = fx.win_tick;
    end
    check("tick_timeout", got, 1'b1);
  endtask

  // k rising edges on every channel in mask, one edge every two cycles.
  task automatic edges(input logic [CH-1:0] mask, input int k);
    repeat (k) begin
      ring_in = ring_in | mask;
      step();
      ring_in = ring_in & ~mask;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    fx.cfg_ring_th  = 16'd3;
    fx.clr_fracture = '0;
    ring_in         = '0;
    model_reset();

    // Reset state.
    rst_n = 1'b0;
    #1;
    check("rst_stu", fx.stu_fracture, 8'h00);
    check("rst_pulse", fx.frac_pulse, 1'b0);
    check("rst_tick", fx.win_tick, 1'b0);
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;

    // 1: idle, th=3: first tick W cycles after ARM, then every W cycles.
    wait_tick();
    check("first_tick_cycle", n, W + 1);
    t0 = n;
    wait_tick();
    check("tick_period", n - t0, W);
    check("idle_stu", fx.stu_fracture, 8'h00);

    // 2: ch2 gets 3 edges, ch5 gets 2 in one window.
    edges(8'h24, 2);
    edges(8'h04, 1);
    wait_tick();
    check("s2_stu", fx.stu_fracture, 8'h04);
    check("s2_pulse", fx.frac_pulse, 1'b1);
    step();
    check("s2_pulse_width", fx.frac_pulse, 1'b0);

    // 3: mid-window clear.
    run(20);
    fx.clr_fracture = 8'h04;
    step();
    check("s3_cleared", fx.stu_fracture, 8'h00);
    wait_tick();
    check("s3_no_reset", fx.stu_fracture, 8'h00);

    // 4: clear on the evaluation cycle of a window where ch2 is set again.
    edges(8'h04, 3);
    wait_tick();
    check("s4_preset", fx.stu_fracture, 8'h04);
    edges(8'h04, 5);
    to_eval_next();
    fx.clr_fracture = 8'h04;
    step();
    check("s4_is_eval", fx.win_tick, 1'b1);
    check("s4_set_wins", fx.stu_fracture, 8'h04);
    check("s4_no_pulse", fx.frac_pulse, 1'b0);

    // 5: threshold 0 disables; a mid-window change only applies next window.
    fx.cfg_ring_th  = 16'd0;
    fx.clr_fracture = 8'hFF;
    step();
    to_eval_next();
    step();
    edges(8'hFF, 120);
    check("s5_disabled", fx.stu_fracture, 8'h00);
    while (n % W != 50) step();
    fx.cfg_ring_th = 16'd10;
    edges(8'hFF, 20);
    wait_tick();
    check("s5_still_disabled", fx.stu_fracture, 8'h00);
    edges(8'hFF, 12);
    wait_tick();
    check("s5_enabled", fx.stu_fracture, 8'hFF);
    check("s5_pulse", fx.frac_pulse, 1'b1);

    // Randomised traffic against the model.
    for (int c = 0; c < 8 * W; c++) begin
      logic [CH-1:0] tog;
      tog = '0;
      for (int i = 0; i < CH; i++) tog[i] = ($urandom_range(0, 3) == 0);
      ring_in = ring_in ^ tog;
      if ($urandom_range(0, 19) == 0) fx.clr_fracture = CH'($urandom);
      if ($urandom_range(0, 49) == 0) fx.cfg_ring_th = 16'($urandom_range(0, 20));
      step();
    end

    // 6: reset mid-window while ch0 toggles; partial window is discarded.
    fx.cfg_ring_th = 16'd20;
    ring_in = '0;
    while (n % W != 52) begin
      ring_in[0] = ~ring_in[0];
      step();
    end
    rst_n = 1'b0;
    #1;
    check("s6_rst_stu", fx.stu_fracture, 8'h00);
    check("s6_rst_pulse", fx.frac_pulse, 1'b0);
    check("s6_rst_tick", fx.win_tick, 1'b0);
    model_reset();
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 2 * W && !got; i++) begin
        ring_in[0] = ~ring_in[0];
        step();
        got = fx.win_tick;
      end
      check("s6_tick_seen", got, 1'b1);
    end
    check("s6_first_tick", n, W + 1);
    check("s6_stu", fx.stu_fracture, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
